// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the multi-cycle shifter: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_unit_seq_step.sv
// Combinational single step: shifts or rotates acc by k (0..STEP) bits.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       mode,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] rot;

    // Rotating the doubled word left leaves the rotated value in the upper half.
    assign rot = {acc, acc} << k;

    always_comb begin
        res = acc;
        case (mode)
            MODE_SLL: res = acc << k;
            MODE_SRL: res = acc >> k;
            MODE_SRA: res = $signed(acc) >>> k;
            MODE_ROL: res = rot[2*WIDTH-1:WIDTH];
            default:  res = acc;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL), at most STEP bits per cycle, start/busy/valid handshake.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o
);

    localparam int KW = $clog2(STEP + 1);
    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

    state_t             state, state_n;
    logic [WIDTH-1:0]   acc, acc_n, dout_n, step_res;
    logic [1:0]         mode_q, mode_n;
    logic [SHAMT_W-1:0] rem, rem_n;
    logic [SHAMT_W:0]   rem_x;
    logic [KW-1:0]      k;
    logic               last;

    // STEP may equal WIDTH, which does not fit in SHAMT_W bits; compare one bit wider.
    assign rem_x = {1'b0, rem};
    assign last  = (rem_x <= STEP_C);
    assign k     = (rem_x < STEP_C) ? KW'(rem) : KW'(STEP);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc  (acc),
        .mode (mode_q),
        .k    (k),
        .res  (step_res)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            acc    <= '0;
            rem    <= '0;
            mode_q <= MODE_SLL;
            data_o <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            rem    <= rem_n;
            mode_q <= mode_n;
            data_o <= dout_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        mode_n  = mode_q;
        dout_n  = data_o;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    acc_n  = data_i;
                    mode_n = mode_i;
                    rem_n  = shamt_i;
                    // A zero shift completes immediately, so the result is loaded here.
                    if (shamt_i == '0) begin
                        state_n = S_DONE;
                        dout_n  = data_i;
                    end else begin
                        state_n = S_SHIFT;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_n = step_res;
                rem_n = rem - SHAMT_W'(k);
                if (last) begin
                    state_n = S_DONE;
                    dout_n  = step_res;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy_o  = (state == S_SHIFT);
    assign valid_o = (state == S_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench: three shifter instances (STEP 1, 4, 8) against a whole-shift reference model.
module tb_shift_unit_seq;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int NDUT    = 3;

    typedef struct {
        logic [WIDTH-1:0] val;
        int unsigned      due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i, start_i;
    logic [1:0]         mode_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;

    logic             busy  [NDUT];
    logic             valid [NDUT];
    logic [WIDTH-1:0] dout  [NDUT];

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Whole-amount reference: shift the operand by s in one go.
    function automatic logic [WIDTH-1:0] ref_shift(logic [1:0] m, logic [WIDTH-1:0] d, int s);
        logic [2*WIDTH-1:0] ext;
        case (m)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b10: begin
                ext = {{WIDTH{d[WIDTH-1]}}, d};
                ext = ext >> s;
                return ext[WIDTH-1:0];
            end
            default: return (d << s) | (d >> (WIDTH - s));
        endcase
    endfunction

    task automatic check(int st, string name, logic [WIDTH-1:0] got, logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL step%0d %s cycle %0d: got %h expected %h", st, name, cyc, got, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : ((g == 1) ? 4 : 8);

        exp_t             q[$];
        exp_t             ex;
        int unsigned      free_at = 0;
        int unsigned      busy_from = 1;
        int unsigned      busy_to = 0;
        int unsigned      rst_at = 0;
        int unsigned      lat;
        logic [WIDTH-1:0] hold = '0;
        logic             ev;

        shift_unit_seq #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .STEP    (ST)
        ) dut (
            .clk_i   (clk),
            .rst_i   (rst_i),
            .start_i (start_i),
            .mode_i  (mode_i),
            .shamt_i (shamt_i),
            .data_i  (data_i),
            .busy_o  (busy[g]),
            .valid_o (valid[g]),
            .data_o  (dout[g])
        );

        // Model side: decide acceptance from the unit's own occupancy and schedule results.
        always @(posedge clk) begin
            if (!rst_i) begin
                while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
                free_at = cyc + 1;
                busy_to = cyc;
                rst_at  = cyc + 1;
            end else if (start_i && cyc >= free_at) begin
                lat = (int'(shamt_i) + ST - 1) / ST + 1;
                ex.val = ref_shift(mode_i, data_i, int'(shamt_i));
                ex.due = cyc + lat;
                q.push_back(ex);
                free_at   = cyc + lat;
                busy_from = cyc + 1;
                busy_to   = cyc + lat - 1;
            end
        end

        always @(negedge clk) begin
            if (cyc >= 1) begin
                if (cyc == rst_at) hold = '0;
                ev = (q.size() > 0 && q[0].due == cyc);
                check(ST, "valid", {31'b0, valid[g]}, {31'b0, ev});
                if (ev) begin
                    ex = q.pop_front();
                    hold = ex.val;
                end
                check(ST, "data", dout[g], hold);
                check(ST, "busy", {31'b0, busy[g]},
                      {31'b0, (cyc >= busy_from && cyc <= busy_to)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        start_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic issue(logic [1:0] m, logic [SHAMT_W-1:0] s, logic [WIDTH-1:0] d);
        start_i = 1'b1;
        mode_i  = m;
        shamt_i = s;
        data_i  = d;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; mode_i = '0; shamt_i = '0; data_i = '0;
        repeat (3) tick();
        rst_i = 1'b1;
        idle(2);

        issue(2'b00, 5'd2, 32'h0000_0003);
        idle(40);
        issue(2'b10, 5'd7, 32'h8000_00F0);
        idle(40);
        issue(2'b11, 5'd8, 32'h1234_5678);
        idle(40);
        for (int m = 0; m < 4; m++) issue(2'(m), 5'd0, 32'hDEAD_BEEF);
        idle(5);

        // Starts while shifting are dropped; a start held through DONE chains ops.
        issue(2'b00, 5'd10, 32'hA5A5_0F0F);
        start_i = 1'b1; mode_i = 2'b01; shamt_i = 5'd3; data_i = 32'hFFFF_0000;
        repeat (3) tick();
        idle(40);
        start_i = 1'b1; mode_i = 2'b11; shamt_i = 5'd5; data_i = 32'h8765_4321;
        repeat (40) tick();
        idle(40);

        // Reset in mid-shift, coinciding with a start request.
        issue(2'b10, 5'd20, 32'h8000_0001);
        idle(5);
        rst_i = 1'b0; start_i = 1'b1; mode_i = 2'b00; shamt_i = 5'd1; data_i = 32'h1;
        tick();
        rst_i = 1'b1;
        idle(40);
        issue(2'b01, 5'd13, 32'hF0F0_F0F0);
        idle(40);

        for (int i = 0; i < 3000; i++) begin
            start_i = ($urandom_range(0, 2) != 0);
            mode_i  = 2'($urandom);
            shamt_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            data_i  = $urandom;
            rst_i   = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_i = 1'b1;
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
